// File: rtl/backprop_hidden_update.sv
// -----------------------------------------------------------------------------
// backprop_hidden_update
//   Weight-update engine for one hidden neuron. On each start it computes the
//   scaled hidden delta g = lr*(so-t)*so*(1-so)*w2*h*(1-h) with one shared
//   float multiplier and two shared float subtractors, then sweeps N_IN
//   input/weight pairs and writes back w_i - g*x_i in ascending order.
//
//   Ports
//     clk_i, reset_n_i          clock (rising edge), async active-low reset
//     start_i                   request one update (sampled only in IDLE)
//     target_i .. learning_rate_i  operands t, so, w2, h, lr (latched on start)
//     rd_addr_o                 read address; x_data_i/w_data_i valid 1 cycle later
//     wr_en_o/wr_addr_o/wr_data_o  1-cycle write strobe with updated weight
//     delta_out_o               unscaled delta, stable from end of P6
//     busy_o, done_o            activity flag and 1-cycle completion pulse
// -----------------------------------------------------------------------------

// Combinational IEEE-754 single multiplier; denormals flush to zero,
// round to nearest even.
module Fmultiplier (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] p_o
);
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic signed [10:0] e;
        logic [47:0]        prod;
        logic [22:0]        m;
        logic               g;
        logic               st;
        logic [23:0]        mr;
        s = a[31] ^ b[31];
        if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) return {s, 31'd0};
        if ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF)) return {s, 8'hFF, 23'd0};
        prod = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
        if (prod[47]) begin
            m  = prod[46:24];
            g  = prod[23];
            st = |prod[22:0];
            e  = e + 11'sd1;
        end else begin
            m  = prod[45:23];
            g  = prod[22];
            st = |prod[21:0];
        end
        mr = {1'b0, m} + {23'd0, (g & (st | m[0]))};
        // Rounding carry into the hidden bit: mantissa is already all zeros
        if (mr[23]) e = e + 11'sd1;
        if (e >= 11'sd255) return {s, 8'hFF, 23'd0};
        if (e <= 11'sd0) return {s, 31'd0};
        return {s, e[7:0], mr[22:0]};
    endfunction

    assign p_o = fmul(a_i, b_i);
endmodule

// Combinational IEEE-754 single adder/subtractor (sub_i=1: a-b);
// denormals flush to zero, round to nearest even.
module Fadder_Fsubtractor (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sub_i,
    output logic [31:0] s_o
);
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b_raw,
                                         input logic sub);
        logic [31:0]        b;
        logic [31:0]        x;
        logic [31:0]        y;
        logic [7:0]         d;
        logic [27:0]        mx;
        logic [27:0]        my;
        logic [27:0]        sm;
        logic [27:0]        sum;
        logic signed [10:0] e;
        logic               g;
        logic               st;
        logic [24:0]        mr;
        b = {b_raw[31] ^ sub, b_raw[30:0]};
        if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? 32'd0 : b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        // x carries the larger magnitude so the mantissa difference never goes negative
        if (b[30:0] > a[30:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        d  = x[30:23] - y[30:23];
        mx = {2'b01, x[22:0], 3'b000};
        my = {2'b01, y[22:0], 3'b000};
        if (d > 8'd27) begin
            sm = 28'd1;
        end else begin
            sm = my >> d;
            if ((sm << d) != my) sm[0] = 1'b1;
        end
        sum = (x[31] == y[31]) ? (mx + sm) : (mx - sm);
        e   = $signed({3'b000, x[30:23]});
        if (sum == 28'd0) return 32'd0;
        if (sum[27]) begin
            sum = {1'b0, sum[27:1]} | {27'd0, sum[0]};
            e   = e + 11'sd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!sum[26]) begin
                    sum = sum << 1;
                    e   = e - 11'sd1;
                end else begin
                    sum = sum;
                end
            end
        end
        g  = sum[2];
        st = |sum[1:0];
        mr = {1'b0, sum[26:3]} + {24'd0, (g & (st | sum[3]))};
        if (mr[24]) e = e + 11'sd1;
        if (e >= 11'sd255) return {x[31], 8'hFF, 23'd0};
        if (e <= 11'sd0) return {x[31], 31'd0};
        return {x[31], e[7:0], mr[22:0]};
    endfunction

    assign s_o = fadd(a_i, b_i, sub_i);
endmodule

module backprop_hidden_update #(
    parameter int          N_IN      = 4,
    parameter int          ADDR_W    = 2,
    parameter int          OP_LAT    = 1,
    parameter int          SKIP_ZERO = 1,
    parameter logic [31:0] ONE       = 32'h3F800000
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic [31:0]       target_i,
    input  logic [31:0]       sigmoid_out_i,
    input  logic [31:0]       layer2_weight_i,
    input  logic [31:0]       hidden_sig_i,
    input  logic [31:0]       learning_rate_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [31:0]       x_data_i,
    input  logic [31:0]       w_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [31:0]       delta_out_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int                CNT_W    = (OP_LAT > 1) ? $clog2(OP_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OP_LAT - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_IN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_P1, S_P2, S_P3, S_P4, S_P5, S_P6, S_P7,
        S_RD, S_M, S_S, S_WR, S_DONE
    } state_e;

    state_e            state_q, state_d, op_next_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_s, skip_s;
    logic [ADDR_W-1:0] idx_q, rd_addr_q, wr_addr_q;
    logic [31:0]       so_q, t_q, w2_q, h_q, lr_q;
    logic [31:0]       loss_q, rso_q, d1_q, rh_q, e_q, hd_q, delta_q, g_q;
    logic [31:0]       x_q, w_q, p_q, wr_data_q;
    logic              wr_en_q, busy_q, done_q;

    logic [31:0] mul_a_s, mul_b_s, add0_a_s, add0_b_s, add1_a_s, add1_b_s;
    logic [31:0] mul_now_s, add0_now_s, add1_now_s;
    logic [95:0] res_now_s, res_s;
    logic [31:0] mul_r_s, add0_r_s, add1_r_s;

    Fmultiplier u_mul (.a_i(mul_a_s), .b_i(mul_b_s), .p_o(mul_now_s));
    Fadder_Fsubtractor u_add0 (.a_i(add0_a_s), .b_i(add0_b_s), .sub_i(1'b1), .s_o(add0_now_s));
    Fadder_Fsubtractor u_add1 (.a_i(add1_a_s), .b_i(add1_b_s), .sub_i(1'b1), .s_o(add1_now_s));

    assign res_now_s = {mul_now_s, add0_now_s, add1_now_s};

    // The float units are modelled as combinational cores followed by
    // OP_LAT-1 stages, so the value seen on the last cycle of a state
    // belongs to the operands presented on its first cycle.
    generate
        if (OP_LAT <= 1) begin : g_no_delay
            assign res_s = res_now_s;
        end else begin : g_delay
            logic [95:0] pipe_q [OP_LAT-1];
            // Result alignment pipeline for the shared float units
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    for (int i = 0; i < OP_LAT - 1; i++) pipe_q[i] <= 96'd0;
                end else begin
                    pipe_q[0] <= res_now_s;
                    for (int i = 1; i < OP_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign res_s = pipe_q[OP_LAT-2];
        end
    endgenerate

    assign mul_r_s  = res_s[95:64];
    assign add0_r_s = res_s[63:32];
    assign add1_r_s = res_s[31:0];

    assign last_s = (cnt_q == CNT_LAST);
    assign skip_s = (SKIP_ZERO != 0) && (delta_q[30:0] == 31'd0);

    // Operand routing of the shared units per computation step
    always_comb begin
        mul_a_s  = 32'd0;
        mul_b_s  = 32'd0;
        add0_a_s = 32'd0;
        add0_b_s = 32'd0;
        add1_a_s = 32'd0;
        add1_b_s = 32'd0;
        case (state_q)
            S_P1: begin
                add0_a_s = so_q;  add0_b_s = t_q;
                add1_a_s = ONE;   add1_b_s = so_q;
            end
            S_P2: begin
                mul_a_s  = so_q;  mul_b_s  = rso_q;
                add1_a_s = ONE;   add1_b_s = h_q;
            end
            S_P3: begin mul_a_s = loss_q;  mul_b_s = d1_q; end
            S_P4: begin mul_a_s = e_q;     mul_b_s = w2_q; end
            S_P5: begin mul_a_s = h_q;     mul_b_s = rh_q; end
            S_P6: begin mul_a_s = e_q;     mul_b_s = hd_q; end
            S_P7: begin mul_a_s = delta_q; mul_b_s = lr_q; end
            // x_data is only guaranteed on the first M cycle; later cycles use the capture
            S_M: begin
                mul_a_s = g_q;
                mul_b_s = (cnt_q == {CNT_W{1'b0}}) ? x_data_i : x_q;
            end
            S_S: begin add0_a_s = w_q; add0_b_s = p_q; end
            default: begin
                mul_a_s = 32'd0;
            end
        endcase
    end

    // Successor of each multi-cycle arithmetic state
    always_comb begin
        op_next_s = S_IDLE;
        case (state_q)
            S_P1:    op_next_s = S_P2;
            S_P2:    op_next_s = S_P3;
            S_P3:    op_next_s = S_P4;
            S_P4:    op_next_s = S_P5;
            S_P5:    op_next_s = S_P6;
            S_P6:    op_next_s = S_P7;
            S_P7:    op_next_s = skip_s ? S_DONE : S_RD;
            S_M:     op_next_s = S_S;
            S_S:     op_next_s = S_WR;
            default: op_next_s = S_IDLE;
        endcase
    end

    // Next-state and operand-hold counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_P1;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_P1, S_P2, S_P3, S_P4, S_P5, S_P6, S_P7, S_M, S_S: begin
                if (last_s) begin
                    state_d = op_next_s;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_RD:    state_d = S_M;
            S_WR:    state_d = (idx_q == IDX_LAST) ? S_DONE : S_RD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath captures, sweep index and registered outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            so_q      <= 32'd0;  t_q    <= 32'd0;  w2_q  <= 32'd0;
            h_q       <= 32'd0;  lr_q   <= 32'd0;  loss_q <= 32'd0;
            rso_q     <= 32'd0;  d1_q   <= 32'd0;  rh_q  <= 32'd0;
            e_q       <= 32'd0;  hd_q   <= 32'd0;  delta_q <= 32'd0;
            g_q       <= 32'd0;  x_q    <= 32'd0;  w_q   <= 32'd0;
            p_q       <= 32'd0;  wr_data_q <= 32'd0;
            idx_q     <= {ADDR_W{1'b0}};
            rd_addr_q <= {ADDR_W{1'b0}};
            wr_addr_q <= {ADDR_W{1'b0}};
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        so_q <= sigmoid_out_i;
                        t_q  <= target_i;
                        w2_q <= layer2_weight_i;
                        h_q  <= hidden_sig_i;
                        lr_q <= learning_rate_i;
                    end
                end
                S_P1: if (last_s) begin loss_q <= add0_r_s; rso_q <= add1_r_s; end
                S_P2: if (last_s) begin d1_q <= mul_r_s; rh_q <= add1_r_s; end
                S_P3: if (last_s) e_q     <= mul_r_s;
                S_P4: if (last_s) e_q     <= mul_r_s;
                S_P5: if (last_s) hd_q    <= mul_r_s;
                S_P6: if (last_s) delta_q <= mul_r_s;
                S_P7: begin
                    if (last_s) begin
                        g_q   <= mul_r_s;
                        idx_q <= {ADDR_W{1'b0}};
                        if (!skip_s) rd_addr_q <= {ADDR_W{1'b0}};
                    end
                end
                S_M: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        x_q <= x_data_i;
                        w_q <= w_data_i;
                    end
                    if (last_s) p_q <= mul_r_s;
                end
                S_S: begin
                    if (last_s) begin
                        wr_data_q <= add0_r_s;
                        wr_addr_q <= idx_q;
                    end
                end
                // Index saturates at the last pair so the sweep never wraps
                S_WR: begin
                    if (idx_q != IDX_LAST) begin
                        idx_q     <= idx_q + ADDR_W'(1);
                        rd_addr_q <= idx_q + ADDR_W'(1);
                    end
                end
                default: begin
                    idx_q <= idx_q;
                end
            endcase
            wr_en_q <= (state_d == S_WR);
            done_q  <= (state_d == S_DONE);
            busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
        end
    end

    assign rd_addr_o   = rd_addr_q;
    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign delta_out_o = delta_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
endmodule

// File: tb/tb_backprop_hidden_update.sv
// -----------------------------------------------------------------------------
// tb_backprop_hidden_update
//   Directed, table-driven bench. Two instances share stimulus: dut uses
//   SKIP_ZERO=1, dut_nz uses SKIP_ZERO=0. A behavioural RAM answers reads one
//   cycle after the address; a negedge monitor logs writes and done pulses.
// -----------------------------------------------------------------------------
module tb_backprop_hidden_update;
    logic        clk = 1'b0;
    logic        reset_n, start;
    logic [31:0] target, so, w2, h, lr;
    logic [1:0]  rd_addr, rd_addr_nz, wr_addr, wr_addr_nz;
    logic [31:0] x_data, w_data, x_data_nz, w_data_nz;
    logic [31:0] wr_data, wr_data_nz, delta_out, delta_out_nz;
    logic        wr_en, wr_en_nz, busy, busy_nz, done, done_nz;
    logic [31:0] xmem [4];
    logic [31:0] wmem [4];

    always #5 clk = ~clk;

    backprop_hidden_update #(.N_IN(4), .ADDR_W(2), .OP_LAT(1), .SKIP_ZERO(1)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .target_i(target),
        .sigmoid_out_i(so), .layer2_weight_i(w2), .hidden_sig_i(h), .learning_rate_i(lr),
        .rd_addr_o(rd_addr), .x_data_i(x_data), .w_data_i(w_data), .wr_en_o(wr_en),
        .wr_addr_o(wr_addr), .wr_data_o(wr_data), .delta_out_o(delta_out),
        .busy_o(busy), .done_o(done));

    backprop_hidden_update #(.N_IN(4), .ADDR_W(2), .OP_LAT(1), .SKIP_ZERO(0)) dut_nz (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .target_i(target),
        .sigmoid_out_i(so), .layer2_weight_i(w2), .hidden_sig_i(h), .learning_rate_i(lr),
        .rd_addr_o(rd_addr_nz), .x_data_i(x_data_nz), .w_data_i(w_data_nz), .wr_en_o(wr_en_nz),
        .wr_addr_o(wr_addr_nz), .wr_data_o(wr_data_nz), .delta_out_o(delta_out_nz),
        .busy_o(busy_nz), .done_o(done_nz));

    // Synchronous-read memory: data for an address appears one cycle later
    always @(posedge clk) begin
        x_data    <= xmem[rd_addr];
        w_data    <= wmem[rd_addr];
        x_data_nz <= xmem[rd_addr_nz];
        w_data_nz <= wmem[rd_addr_nz];
    end

    int          wr_cnt, wr_cnt_nz, done_cnt;
    logic [1:0]  log_addr [8];
    logic [31:0] log_data [8];
    logic [31:0] log_data_nz [8];

    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_cnt < 8) begin
                log_addr[wr_cnt] = wr_addr;
                log_data[wr_cnt] = wr_data;
            end
            wr_cnt++;
        end
        if (wr_en_nz) begin
            if (wr_cnt_nz < 8) log_data_nz[wr_cnt_nz] = wr_data_nz;
            wr_cnt_nz++;
        end
        if (done) done_cnt++;
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_cnt = 0;
        wr_cnt_nz = 0;
        done_cnt = 0;
    endtask

    // Pulse start; optionally re-pulse at cycles poke_a/poke_b; n = cycle of done (P1 is cycle 1)
    task automatic run_op(input int poke_a, input int poke_b, output int n, output logic busy1);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        busy1 = busy;
        while (!done && n < 200) begin
            start = (n == poke_a) || (n == poke_b);
            step();
            n++;
        end
        start = 1'b0;
    endtask

    typedef struct packed {
        logic [31:0] so, t, w2, h, lr, x0, w0, exp_delta, exp_wr0;
    } vec_t;

    vec_t        vecs [3];
    logic [31:0] w_rest [4];
    int          n;
    logic        b1;

    task automatic load_vec(input vec_t v);
        so = v.so; target = v.t; w2 = v.w2; h = v.h; lr = v.lr;
        xmem[0] = v.x0;
        wmem[0] = v.w0;
        for (int j = 1; j < 4; j++) begin
            xmem[j] = 32'h00000000;
            wmem[j] = w_rest[j];
        end
    endtask

    initial begin
        vecs[0] = '{so: 32'h3F400000, t: 32'h3F800000, w2: 32'h3F000000, h: 32'h3F000000,
                    lr: 32'h3F000000, x0: 32'h3F800000, w0: 32'h3E800000,
                    exp_delta: 32'hBBC00000, exp_wr0: 32'h3E818000};
        vecs[1] = '{so: 32'h3F000000, t: 32'h00000000, w2: 32'h3F800000, h: 32'h3F000000,
                    lr: 32'h3F800000, x0: 32'h3F800000, w0: 32'h3F800000,
                    exp_delta: 32'h3D000000, exp_wr0: 32'h3F780000};
        vecs[2] = '{so: 32'h3F400000, t: 32'h3F000000, w2: 32'hC0000000, h: 32'h3F400000,
                    lr: 32'h3E800000, x0: 32'h40000000, w0: 32'h00000000,
                    exp_delta: 32'hBC900000, exp_wr0: 32'h3C100000};
        w_rest[0] = 32'h00000000;
        w_rest[1] = 32'h40490FDB;
        w_rest[2] = 32'hC0200000;
        w_rest[3] = 32'h3DCCCCCD;

        // Reset state
        reset_n = 1'b0; start = 1'b0;
        so = 32'd0; target = 32'd0; w2 = 32'd0; h = 32'd0; lr = 32'd0;
        for (int j = 0; j < 4; j++) begin xmem[j] = 32'd0; wmem[j] = 32'd0; end
        clear_logs();
        step(); step();
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset wr_en", {31'd0, wr_en}, 32'd0);
        chk("reset delta_out", delta_out, 32'd0);
        reset_n = 1'b1;
        step();

        // Table-driven full updates
        for (int i = 0; i < 3; i++) begin
            load_vec(vecs[i]);
            clear_logs();
            run_op(-1, -1, n, b1);
            chk($sformatf("v%0d busy in P1", i), {31'd0, b1}, 32'd1);
            chk($sformatf("v%0d done latency", i), 32'(n), 32'd24);
            chk($sformatf("v%0d busy at done", i), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d delta_out", i), delta_out, vecs[i].exp_delta);
            chk($sformatf("v%0d delta_out nz", i), delta_out_nz, vecs[i].exp_delta);
            chk($sformatf("v%0d write count", i), 32'(wr_cnt), 32'd4);
            chk($sformatf("v%0d wr_data[0]", i), log_data[0], vecs[i].exp_wr0);
            for (int j = 0; j < 4; j++)
                chk($sformatf("v%0d wr_addr #%0d", i, j), {30'd0, log_addr[j]}, 32'(j));
            for (int j = 1; j < 4; j++)
                chk($sformatf("v%0d wr_data[%0d]", i, j), log_data[j], w_rest[j]);
            step();
            chk($sformatf("v%0d done pulse width", i), {31'd0, done}, 32'd0);
            chk($sformatf("v%0d wr_addr hold", i), {30'd0, wr_addr}, 32'd3);
            chk($sformatf("v%0d wr_data hold", i), wr_data, w_rest[3]);
        end

        // Zero delta: skip on dut, full unchanged sweep on dut_nz
        so = 32'h3F000000; target = 32'h3F000000; w2 = 32'h3F800000;
        h = 32'h3F000000; lr = 32'h3F800000;
        for (int j = 0; j < 4; j++) begin xmem[j] = 32'd0; wmem[j] = 32'h40490FDB; end
        wmem[3] = 32'h3DCCCCCD;
        clear_logs();
        run_op(-1, -1, n, b1);
        chk("skip done latency", 32'(n), 32'd8);
        chk("skip delta_out", delta_out, 32'd0);
        while (!done_nz && n < 200) begin step(); n++; end
        chk("noskip done latency", 32'(n), 32'd24);
        chk("skip write count", 32'(wr_cnt), 32'd0);
        chk("noskip write count", 32'(wr_cnt_nz), 32'd4);
        chk("noskip delta_out", delta_out_nz, 32'd0);
        for (int j = 0; j < 4; j++)
            chk($sformatf("noskip wr_data[%0d]", j), log_data_nz[j], wmem[j]);
        step();

        // Start pulses while busy are ignored
        load_vec(vecs[0]);
        clear_logs();
        run_op(5, 15, n, b1);
        chk("busy-start latency", 32'(n), 32'd24);
        repeat (6) step();
        chk("busy-start done count", 32'(done_cnt), 32'd1);
        chk("busy-start write count", 32'(wr_cnt), 32'd4);
        chk("busy-start wr_data[0]", log_data[0], 32'h3E818000);

        // Reset during sweep at index 2
        clear_logs();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (wr_cnt < 2 && n < 200) begin step(); n++; end
        chk("abort reached index 2", 32'(wr_cnt), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort wr_en", {31'd0, wr_en}, 32'd0);
        chk("abort wr_addr", {30'd0, wr_addr}, 32'd0);
        chk("abort wr_data", wr_data, 32'd0);
        chk("abort delta_out", delta_out, 32'd0);
        chk("abort rd_addr", {30'd0, rd_addr}, 32'd0);
        repeat (4) step();
        reset_n = 1'b1;
        repeat (30) step();
        chk("abort no further writes", 32'(wr_cnt), 32'd2);
        chk("abort no done", 32'(done_cnt), 32'd0);
        clear_logs();
        run_op(-1, -1, n, b1);
        chk("post-abort latency", 32'(n), 32'd24);
        chk("post-abort delta_out", delta_out, 32'hBBC00000);
        chk("post-abort wr_data[0]", log_data[0], 32'h3E818000);
        chk("post-abort write count", 32'(wr_cnt), 32'd4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
